// File: rtl/seq_sort_nb_pkg.sv
// Shared definitions for the sequential sorter: FSM state encoding and a
// constant-evaluable clog2 used for index sizing.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_sort_nb_cmp_swap.sv
// Combinational compare-and-swap cell: orders an adjacent entry pair
// ascending (dir=0) or descending (dir=1); equal values are never swapped.
module cmp_swap_nb #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         dir,
  output logic [n-1:0] lo_out,
  output logic [n-1:0] hi_out,
  output logic         swap
);

  always_comb begin
    swap   = dir ? (a < b) : (a > b);
    lo_out = swap ? b : a;
    hi_out = swap ? a : b;
  end

endmodule

// File: rtl/seq_sort_nb.sv
// Parametrised in-place early-exit bubble sorter, one compare-and-swap per clock.
// Define SORT_SWAP_CNT_EN to add the saturating 16-bit swap_cnt output.
module seq_sort_nb
  import sort_pkg::*;
#(
  parameter int n  = 8,
  parameter int M  = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [n-1:0]  wr_data,
  input  logic          desc,
  input  logic          start,
  input  logic [AW-1:0] rd_addr,
  output logic [n-1:0]  rd_data,
  output logic          busy,
  output logic          done
`ifdef SORT_SWAP_CNT_EN
  ,
  output logic [15:0]   swap_cnt
`endif
);

  localparam int IW = (AW > clog2(M)) ? AW : clog2(M);
  localparam logic [IW-1:0] LAST_PASS = IW'(M - 2);

  state_t state, nxt;

  logic [n-1:0]  mem [M];
  logic [IW-1:0] idx, pass;
  logic [IW-1:0] idx_n;
  logic          swapped;
  logic          dir;

  logic [n-1:0]  lo_out, hi_out;
  logic          swap_now;
  logic          last_cmp;
  logic          finish;

  assign idx_n = idx + 1'b1;

  cmp_swap_nb #(.n(n)) u_cmp (
    .a      (mem[idx]),
    .b      (mem[idx_n]),
    .dir    (dir),
    .lo_out (lo_out),
    .hi_out (hi_out),
    .swap   (swap_now)
  );

  // Final compare of each pass sits at M-2-pass; the range shrinks as the
  // largest (or smallest) value settles at the far end.
  always_comb begin
    last_cmp = (idx == (LAST_PASS - pass));
    finish   = last_cmp && (!(swapped || swap_now) || (pass == LAST_PASS));
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (start) nxt = CMP;
      CMP: begin
        busy = 1'b1;
        if (finish) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < M) rd_data = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      idx     <= '0;
      pass    <= '0;
      swapped <= 1'b0;
      dir     <= 1'b0;
      for (int unsigned i = 0; i < M; i++) mem[i] <= '0;
`ifdef SORT_SWAP_CNT_EN
      swap_cnt <= '0;
`endif
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (wr_en && (int'(wr_addr) < M)) mem[wr_addr] <= wr_data;
          if (start) begin
            dir     <= desc;
            idx     <= '0;
            pass    <= '0;
            swapped <= 1'b0;
`ifdef SORT_SWAP_CNT_EN
            swap_cnt <= '0;
`endif
          end
        end
        CMP: begin
          if (swap_now) begin
            mem[idx]   <= lo_out;
            mem[idx_n] <= hi_out;
`ifdef SORT_SWAP_CNT_EN
            if (swap_cnt != '1) swap_cnt <= swap_cnt + 16'd1;
`endif
          end
          if (last_cmp) begin
            if (!finish) begin
              pass    <= pass + 1'b1;
              idx     <= '0;
              swapped <= 1'b0;
            end
          end else begin
            idx     <= idx_n;
            swapped <= swapped | swap_now;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sort_nb.sv
// Directed and randomised checks of seq_sort_nb at M=4/n=8, M=3 and M=8/n=12.
module tb_seq_sort_nb;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // M=4, n=8
  logic       wr_en4 = 0, desc4 = 0, start4 = 0;
  logic [1:0] wr_addr4 = 0, rd_addr4 = 0;
  logic [7:0] wr_data4 = 0, rd_data4;
  logic       busy4, done4;
  // M=3, n=8 (address space larger than entry count)
  logic       wr_en3 = 0, desc3 = 0, start3 = 0;
  logic [1:0] wr_addr3 = 0, rd_addr3 = 0;
  logic [7:0] wr_data3 = 0, rd_data3;
  logic       busy3, done3;
  // M=8, n=12
  logic        wr_en8 = 0, desc8 = 0, start8 = 0;
  logic [2:0]  wr_addr8 = 0, rd_addr8 = 0;
  logic [11:0] wr_data8 = 0, rd_data8;
  logic        busy8, done8;
`ifdef SORT_SWAP_CNT_EN
  logic [15:0] sc4, sc3, sc8;
`endif

  seq_sort_nb #(.n(8), .M(4), .AW(2)) u4 (
    .clk(clk), .clr(clr), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .desc(desc4), .start(start4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .busy(busy4), .done(done4)
`ifdef SORT_SWAP_CNT_EN
    , .swap_cnt(sc4)
`endif
  );

  seq_sort_nb #(.n(8), .M(3), .AW(2)) u3 (
    .clk(clk), .clr(clr), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .desc(desc3), .start(start3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .busy(busy3), .done(done3)
`ifdef SORT_SWAP_CNT_EN
    , .swap_cnt(sc3)
`endif
  );

  seq_sort_nb #(.n(12), .M(8), .AW(3)) u8 (
    .clk(clk), .clr(clr), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
    .desc(desc8), .start(start8), .rd_addr(rd_addr8), .rd_data(rd_data8),
    .busy(busy8), .done(done8)
`ifdef SORT_SWAP_CNT_EN
    , .swap_cnt(sc8)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Entry i of a packed vector lives in bits [8i+7:8i].
  task automatic load4(input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en4 = 1; wr_addr4 = 2'(i); wr_data4 = v[8*i +: 8];
    end
    @(negedge clk);
    wr_en4 = 0;
  endtask

  // Starts a sort on the current contents; lat = cycle index of done (1 = first after start).
  task automatic sort4(input logic d, output int lat);
    desc4 = d; start4 = 1;
    @(negedge clk);
    start4 = 0; lat = 1;
    while (!done4 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic read4(input string nm, input logic [31:0] ex);
    for (int i = 0; i < 4; i++) begin
      rd_addr4 = 2'(i);
      #1;
      chk(nm, {24'd0, rd_data4}, {24'd0, ex[8*i +: 8]});
    end
  endtask

  typedef struct {
    logic [31:0] in;
    logic        d;
    logic [31:0] ex;
    int          lat;
    int          sc;
  } vec_t;

  vec_t tv[9];

  initial begin
    int lat, ndone, first;
    logic [11:0] v8[8], m8[8];
    logic [11:0] t;
    int inv;

    if ((1 << 2) < 4 || (1 << 2) < 3 || (1 << 3) < 8)
      $fatal(1, "FAIL param_aw: address width too small for entry count");

    tv[0] = '{32'h10203040, 1'b0, 32'h40302010, 7, 6};
    tv[1] = '{32'h04030201, 1'b0, 32'h04030201, 4, 0};
    tv[2] = '{32'h04030201, 1'b1, 32'h01020304, 7, 6};
    tv[3] = '{32'hFF000505, 1'b0, 32'hFF050500, 7, 2};
    tv[4] = '{32'h04020103, 1'b0, 32'h04030201, 6, 2};
    tv[5] = '{32'h04030102, 1'b0, 32'h04030201, 6, 1};
    tv[6] = '{32'h00000000, 1'b1, 32'h00000000, 4, 0};
    tv[7] = '{32'h40302010, 1'b1, 32'h10203040, 7, 6};
    tv[8] = '{32'h01070907, 1'b1, 32'h01070709, 6, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy4}, 0);
    chk("rst_done", {31'd0, done4}, 0);
    read4("rst_data", 32'h0);
`ifdef SORT_SWAP_CNT_EN
    chk("rst_swap_cnt", {16'd0, sc4}, 0);
`endif
    clr = 0;

    // Table-driven sorts on the M=4 instance
    foreach (tv[k]) begin
      load4(tv[k].in);
      sort4(tv[k].d, lat);
      chk($sformatf("lat_v%0d", k), lat, tv[k].lat);
      chk($sformatf("busy_at_done_v%0d", k), {31'd0, busy4}, 0);
      read4($sformatf("data_v%0d", k), tv[k].ex);
`ifdef SORT_SWAP_CNT_EN
      chk($sformatf("swap_cnt_v%0d", k), {16'd0, sc4}, tv[k].sc);
`endif
      @(negedge clk);
      chk($sformatf("done_pulse_v%0d", k), {31'd0, done4}, 0);
`ifdef SORT_SWAP_CNT_EN
      chk($sformatf("swap_cnt_hold_v%0d", k), {16'd0, sc4}, tv[k].sc);
`endif
    end

    // Write and start during CMP are dropped, not queued
    load4(32'h06070809);
    desc4 = 0; start4 = 1;
    ndone = 0; first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start4 = 0;
      if (c == 2) begin wr_en4 = 1; wr_addr4 = 0; wr_data4 = 8'hAA; start4 = 1; end
      if (c == 3) begin wr_en4 = 0; start4 = 0; end
      if (done4) begin ndone++; if (first == 0) first = c; end
    end
    chk("busy_ign_ndone", ndone, 1);
    chk("busy_ign_lat", first, 7);
    read4("busy_ign_data", 32'h09080706);

    // Reset in the second CMP cycle
    load4(32'h01020304);
    sort4_abort: begin
      desc4 = 0; start4 = 1;
      @(negedge clk);
      start4 = 0;
      @(negedge clk);
      clr = 1;
      #1;
      chk("abort_busy", {31'd0, busy4}, 0);
      chk("abort_done", {31'd0, done4}, 0);
      read4("abort_data", 32'h0);
`ifdef SORT_SWAP_CNT_EN
      chk("abort_swap_cnt", {16'd0, sc4}, 0);
`endif
      @(negedge clk);
      clr = 0;
      ndone = 0;
      repeat (10) begin
        @(negedge clk);
        if (done4) ndone++;
      end
      chk("abort_no_done", ndone, 0);
    end
    load4(32'h03040102);
    sort4(1'b0, lat);
    chk("post_abort_lat", lat, 6);
    read4("post_abort_data", 32'h04030201);

    // M=3: writes to addr 3 ignored, addr 3 reads 0, pass cap at M-2
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en3 = 1; wr_addr3 = 2'(i); wr_data3 = (i == 3) ? 8'h55 : 8'(9 - i);
    end
    @(negedge clk);
    wr_en3 = 0; desc3 = 0; start3 = 1;
    @(negedge clk);
    start3 = 0; lat = 1;
    while (!done3 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("m3_lat", lat, 4);
    for (int i = 0; i < 4; i++) begin
      rd_addr3 = 2'(i);
      #1;
      chk($sformatf("m3_data%0d", i), {24'd0, rd_data3}, (i == 3) ? 0 : 7 + i);
    end
`ifdef SORT_SWAP_CNT_EN
    chk("m3_swap_cnt", {16'd0, sc3}, 3);
`endif

    // M=8, n=12 random against a reference insertion sort
    for (int it = 0; it < 200; it++) begin
      inv = 0;
      for (int i = 0; i < 8; i++) v8[i] = 12'($urandom_range(0, 4095));
      for (int i = 0; i < 8; i++)
        for (int j = i + 1; j < 8; j++)
          if ((it % 2 == 1) ? (v8[i] < v8[j]) : (v8[i] > v8[j])) inv++;
      m8 = v8;
      for (int i = 1; i < 8; i++) begin
        t = m8[i];
        for (int j = i - 1; j >= 0; j--) begin
          if ((it % 2 == 1) ? (m8[j] < t) : (m8[j] > t)) begin
            m8[j + 1] = m8[j];
            m8[j] = t;
          end else break;
        end
      end
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        wr_en8 = 1; wr_addr8 = 3'(i); wr_data8 = v8[i];
      end
      @(negedge clk);
      wr_en8 = 0; desc8 = (it % 2 == 1); start8 = 1;
      @(negedge clk);
      start8 = 0; lat = 1;
      while (!done8 && lat < 64) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("m8_lat_it%0d", it), {31'd0, (lat >= 8 && lat <= 29)}, 1);
      for (int i = 0; i < 8; i++) begin
        rd_addr8 = 3'(i);
        #1;
        chk($sformatf("m8_it%0d_e%0d", it, i), {20'd0, rd_data8}, {20'd0, m8[i]});
      end
`ifdef SORT_SWAP_CNT_EN
      chk($sformatf("m8_swap_cnt_it%0d", it), {16'd0, sc8}, inv);
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_sort_nb.md
Name: seq_sort_nb

Overview:
- Parametrised sequential sorter. Generalises the fixed four-value sorter to M words of n bits each, with a selectable sort direction.
- Values are loaded through a write port and sorted in place by an early-exit bubble-sort FSM that does one compare-and-swap per clock.
- Results are read back through an asynchronous read port. The read port feeds the display path: seg/an muxing via the existing BCD display mux.

Parameters:
- n, 8: data word width in bits.
- M, 4: number of entries. Legal range 2..64.
- AW, 2: address width. Must satisfy 2^AW >= M. The bench checks this.

Ports:
- clk  input  1  system clock.
- clr  input  1  reset, asynchronous, active-high.
- wr_en  input  1  write strobe. Honoured only in IDLE.
- wr_addr  input  AW  write address. Addresses >= M are ignored.
- wr_data  input  n  write data.
- desc  input  1  direction: 0 = ascending, 1 = descending. Sampled when start is accepted.
- start  input  1  request to sort. Honoured only in IDLE.
- rd_addr  input  AW  read address. Addresses >= M read as 0.
- rd_data  output  n  combinational read of entry rd_addr.
- busy  output  1  high while the FSM is in CMP.
- done  output  1  one-cycle pulse when the sort is complete.

Behaviour:
- Reset (clr=1, async): all entries 0, FSM to IDLE, busy=0, done=0, pass=0, idx=0, swapped=0, dir=0. Reset mid-sort aborts immediately; entries are cleared and no done pulse is produced.
- States: IDLE, CMP, DONE.
- IDLE:
  - wr_en writes wr_data to entry wr_addr at the clock edge.
  - If start=1 on that edge: latch dir<=desc, idx<=0, pass<=0, swapped<=0, go to CMP.
  - If wr_en and start are both high on the same edge, the write occurs and the sort starts on the updated data.
- CMP (one compare per cycle):
  - Compare a=entry[idx] and b=entry[idx+1].
  - Swap when (dir=0 and a>b) or (dir=1 and a<b). Equal values are never swapped, so the sort is stable.
  - At idx = M-2-pass (last compare of the pass):
    - If no swap occurred in this pass, including the current cycle, go to DONE.
    - Else if pass = M-2, go to DONE.
    - Else pass<=pass+1, idx<=0, swapped<=0, stay in CMP.
  - Otherwise idx<=idx+1 and swapped<=swapped|swap_now.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency, measured from the start edge to the done cycle:
  - Already sorted: M-1 compare cycles, then DONE.
  - Worst case: M(M-1)/2 compare cycles, then DONE.
  - For M=4: minimum 3 compares, maximum 6 compares.
- Input handling:
  - wr_en and start are ignored in CMP and DONE; no queuing.
  - rd_data reflects live contents, including intermediate swaps while busy.
- Arithmetic: unsigned comparison over the full n bits. idx and pass are sized to AW bits.

Optional Feature:
- Macro SORT_SWAP_CNT_EN.
- When defined:
  - Adds output swap_cnt (16 bits).
  - Cleared to 0 when start is accepted and on clr.
  - Increments on every swap; saturates at 16'hFFFF.
  - Holds its value after done until the next start.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package sort_pkg holds:
  - the state encoding (IDLE=2'd0, CMP=2'd1, DONE=2'd2);
  - a clog2 function used to derive the width of idx and pass.
- One sub-module, cmp_swap_nb (n-bit): a combinational comparator plus two 2:1 muxes.
  - Inputs: a, b, dir.
  - Outputs: lo_out, hi_out, swap.
  - seq_sort_nb instantiates one copy on entry[idx] and entry[idx+1].

Test Plan:
- Reversed input, ascending. M=4, n=8, write {0x40,0x30,0x20,0x10} to addr 0..3, desc=0, start. Expect done 7 cycles after start, reads {0x10,0x20,0x30,0x40}, swap_cnt=6.
- Already sorted. Write {1,2,3,4}, desc=0, start. Expect done on the 4th cycle after start and data unchanged. Then repeat with desc=1 and expect {4,3,2,1}.
- Duplicates and stability. Write {5,5,0,0xFF}, desc=0. Expect {0,5,5,0xFF} with no swap counted between the equal 5s.
- Ignored inputs while busy. Write {9,8,7,6}, start, then pulse wr_en addr0=0xAA and start during CMP. Expect the write to be ignored, a single done pulse, and result {6,7,8,9}.
- Reset mid-sort. Assert clr on the 2nd CMP cycle. Expect busy=0, done never pulses, all entries read 0, and a subsequent sort operates normally.
- Scaling. M=8, n=12, random 0..4095 values for 200 iterations, both directions. Expect the result to match a reference model and latency to be within [M-1, M(M-1)/2]+1.
